// File: rtl/s_link_tx_sched.sv
// rtl/s_link_tx_sched.sv - round-robin scheduler sharing one tx link buffer among N_REQ requesters
// Grant, write-port mux, length check, write timeout, line-time pacing and inter-frame gap.
module s_link_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int CYC_PER_BYTE = 40,
  parameter int OVHD_CYC     = 320,
  parameter int GAP_CYC      = 64,
  parameter int MAX_LEN      = 1024,
  parameter int WR_TMO       = 4096
) (
  input  logic                 sys_clk,
  input  logic                 glb_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ*11-1:0]  i_req_len,
  input  logic [N_REQ-1:0]     i_wren,
  input  logic [N_REQ*11-1:0]  i_waddr,
  input  logic [N_REQ*8-1:0]   i_wdata,
  input  logic [N_REQ-1:0]     i_wr_done,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [N_REQ-1:0]     o_sent,
  output logic [N_REQ-1:0]     o_err,
  output logic                 o_txbuf_wren,
  output logic [10:0]          o_txbuf_waddr,
  output logic [7:0]           o_txbuf_wdata,
  output logic                 o_tx_start,
  output logic [10:0]          o_tx_data_len,
  output logic                 o_busy
);

  localparam int          IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [23:0] CPB      = 24'(CYC_PER_BYTE);
  localparam logic [23:0] OVH      = 24'(OVHD_CYC);
  localparam logic [23:0] GAP_LOAD = 24'(GAP_CYC - 1);
  localparam logic [23:0] TMO_LAST = 24'(WR_TMO - 1);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, GRANT, START, SEND, GAP} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] gidx_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] sent_q;
  logic [N_REQ-1:0] err_q;
  logic [23:0]      cnt_q;
  logic             wren_q;
  logic [10:0]      waddr_q;
  logic [7:0]       wdata_q;
  logic             tx_start_q;
  logic [10:0]      tx_len_q;

  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             pick_vld;
  logic [IDX_W-1:0] nxt_ptr;
  logic [N_REQ-1:0] gidx_oh;
  logic             sel_req;
  logic             sel_wren;
  logic             sel_done;
  logic [10:0]      sel_waddr;
  logic [10:0]      sel_len;
  logic [7:0]       sel_wdata;
  logic             len_ok;

  // Scan from the pointer downward so the nearest requester after it wins.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (i_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    sel_req   = 1'b0;
    sel_wren  = 1'b0;
    sel_done  = 1'b0;
    sel_waddr = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (IDX_W'(r) == gidx_q) begin
        sel_req   = i_req[r];
        sel_wren  = i_wren[r];
        sel_done  = i_wr_done[r];
        sel_waddr = i_waddr[r*11 +: 11];
        sel_len   = i_req_len[r*11 +: 11];
        sel_wdata = i_wdata[r*8 +: 8];
      end
    end
  end

  assign len_ok  = (sel_len != 11'd0) && (sel_len <= MAX_L);
  assign gidx_oh = N_REQ'(1) << gidx_q;
  assign nxt_ptr = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge sys_clk or negedge glb_rst) begin
    if (!glb_rst) begin
      state_q    <= IDLE;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      sent_q     <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      wren_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      tx_start_q <= 1'b0;
      tx_len_q   <= '0;
    end else begin
      sent_q     <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      wren_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gidx_q  <= pick_idx;
            gnt_q   <= N_REQ'(1) << pick_idx;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          wren_q <= sel_wren;
          if (sel_wren) begin
            waddr_q <= sel_waddr;
            wdata_q <= sel_wdata;
          end
          // wr_done is checked first so it beats a coincident timeout.
          if (sel_done) begin
            gnt_q <= '0;
            if (len_ok) begin
              tx_len_q   <= sel_len;
              tx_start_q <= 1'b1;
              state_q    <= START;
            end else begin
              err_q    <= gidx_oh;
              cnt_q    <= GAP_LOAD;
              rr_ptr_q <= nxt_ptr;
              state_q  <= GAP;
            end
          end else if (!sel_req || cnt_q == TMO_LAST) begin
            gnt_q    <= '0;
            err_q    <= gidx_oh;
            cnt_q    <= GAP_LOAD;
            rr_ptr_q <= nxt_ptr;
            state_q  <= GAP;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        START: begin
          // The START cycle is the first line cycle of the frame.
          cnt_q   <= {13'd0, tx_len_q} * CPB + OVH - 24'd1;
          state_q <= SEND;
        end
        SEND: begin
          if (cnt_q == 24'd1) begin
            sent_q   <= gidx_oh;
            cnt_q    <= GAP_LOAD;
            rr_ptr_q <= nxt_ptr;
            state_q  <= GAP;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        GAP: begin
          if (cnt_q == 24'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gnt         = gnt_q;
  assign o_sent        = sent_q;
  assign o_err         = err_q;
  assign o_txbuf_wren  = wren_q;
  assign o_txbuf_waddr = waddr_q;
  assign o_txbuf_wdata = wdata_q;
  assign o_tx_start    = tx_start_q;
  assign o_tx_data_len = tx_len_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_s_link_tx_sched.sv
// tb/tb_s_link_tx_sched.sv - directed scoreboard bench for s_link_tx_sched
`timescale 1ns/1ps
module tb_s_link_tx_sched;

  logic        sys_clk = 1'b0;
  logic        glb_rst;
  logic [3:0]  i_req;
  logic [43:0] i_req_len;
  logic [3:0]  i_wren;
  logic [43:0] i_waddr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wr_done;
  logic [3:0]  o_gnt;
  logic [3:0]  o_sent;
  logic [3:0]  o_err;
  logic        o_txbuf_wren;
  logic [10:0] o_txbuf_waddr;
  logic [7:0]  o_txbuf_wdata;
  logic        o_tx_start;
  logic [10:0] o_tx_data_len;
  logic        o_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_gnt[$];
  int exp_len[$];
  int exp_cmp[$];
  int exp_wr[$];
  logic [3:0] prev_gnt = 4'b0;
  int start_c, sent_c, gnt_c, err_c;

  s_link_tx_sched dut (
    .sys_clk       (sys_clk),
    .glb_rst       (glb_rst),
    .i_req         (i_req),
    .i_req_len     (i_req_len),
    .i_wren        (i_wren),
    .i_waddr       (i_waddr),
    .i_wdata       (i_wdata),
    .i_wr_done     (i_wr_done),
    .o_gnt         (o_gnt),
    .o_sent        (o_sent),
    .o_err         (o_err),
    .o_txbuf_wren  (o_txbuf_wren),
    .o_txbuf_waddr (o_txbuf_waddr),
    .o_txbuf_wdata (o_txbuf_wdata),
    .o_tx_start    (o_tx_start),
    .o_tx_data_len (o_tx_data_len),
    .o_busy        (o_busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {19'd0, o_gnt, o_sent, o_err, o_txbuf_wren, o_txbuf_waddr, o_txbuf_wdata,
            o_tx_start, o_tx_data_len, o_busy};
  endfunction

  function automatic bit evt(input int kind);
    case (kind)
      0:       return o_gnt != 4'b0;
      1:       return (o_sent | o_err) != 4'b0;
      default: return !o_busy;
    endcase
  endfunction

  task automatic wait_evt(input int kind, input int budget, input string tag);
    int n = 0;
    while (!evt(kind) && n < budget) begin
      tick();
      n++;
    end
    if (!evt(kind)) chk(tag, 64'(evt(kind)), 64'd1);
  endtask

  task automatic pulse_done(input int idx, input int len);
    i_req_len[idx*11 +: 11] = 11'(len);
    i_wr_done[idx] = 1'b1;
    tick();
    i_wr_done = 4'b0;
  endtask

  // Scoreboard side: every grant edge, start, completion and buffer write is matched in order.
  always @(negedge sys_clk) begin
    int e;
    logic [3:0] oh;
    if (o_gnt != 4'b0 && prev_gnt == 4'b0) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(o_gnt), 64'd0);
      else begin
        e = exp_gnt.pop_front();
        oh = 4'b0001 << e;
        chk("gnt_order", 64'(o_gnt), 64'(oh));
      end
    end
    prev_gnt <= o_gnt;
    if (o_tx_start) begin
      if (exp_len.size() == 0) chk("start_unexpected", 64'(o_tx_start), 64'd0);
      else chk("start_len", 64'(o_tx_data_len), 64'(exp_len.pop_front()));
    end
    if ((o_sent | o_err) != 4'b0) begin
      if (exp_cmp.size() == 0) chk("cmp_unexpected", 64'({o_sent, o_err}), 64'd0);
      else begin
        e = exp_cmp.pop_front();
        oh = 4'b0001 << (e & 3);
        chk("completion", 64'({o_sent, o_err}), (e >= 16) ? 64'({4'b0, oh}) : 64'({oh, 4'b0}));
      end
    end
    if (o_txbuf_wren) begin
      if (exp_wr.size() == 0) chk("txbuf_unexpected", 64'({o_txbuf_waddr, o_txbuf_wdata}), 64'h7ffff);
      else chk("txbuf_write", 64'({o_txbuf_waddr, o_txbuf_wdata}), 64'(exp_wr.pop_front()));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    glb_rst = 1'b0; i_req = '0; i_wren = '0; i_wr_done = '0;
    i_req_len = '0; i_waddr = '0; i_wdata = '0;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 64'd0);
    glb_rst = 1'b1;
    tick();
    chk("idle_after_reset", 64'(o_busy), 64'd0);

    // Single frame from requester 0, with requester 1 writing alongside.
    i_req = 4'b0001;
    exp_gnt.push_back(0);
    tick();
    chk("gnt_latency", 64'(o_gnt), 64'h1);
    for (int w = 0; w < 3; w++) begin
      i_wren = 4'b0011;
      i_waddr[10:0]  = 11'(w);
      i_wdata[7:0]   = 8'(8'hA0 + w);
      i_waddr[21:11] = 11'(100 + w);
      i_wdata[15:8]  = 8'(8'h50 + w);
      exp_wr.push_back(int'({11'(w), 8'(8'hA0 + w)}));
      tick();
    end
    i_wren = 4'b0010;
    tick();
    i_wren = 4'b0;
    exp_len.push_back(3);
    exp_cmp.push_back(0);
    pulse_done(0, 3);
    chk("start_latency", 64'(o_tx_start), 64'd1);
    chk("gnt_drop_on_done", 64'(o_gnt), 64'd0);
    start_c = cyc;
    wait_evt(1, 1000, "wait_sent0");
    chk("send_cycles", 64'(cyc - start_c), 64'd440);
    sent_c = cyc;
    i_req = 4'b0;
    wait_evt(2, 200, "wait_idle_a");
    chk("gap_cycles", 64'(cyc - sent_c), 64'd64);
    chk("tx_len_hold", 64'(o_tx_data_len), 64'd3);

    // Fairness from a fresh pointer.
    glb_rst = 1'b0;
    tick();
    glb_rst = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) exp_gnt.push_back(k % 4);
    i_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_evt(0, 1000, "wait_gnt_fair");
      if (k > 0) chk("no_repeat", 64'(o_gnt), 64'(4'b0001 << (k % 4)));
      if (k < 4) begin
        exp_len.push_back(1);
        exp_cmp.push_back(k % 4);
        pulse_done(k % 4, 1);
      end else begin
        exp_cmp.push_back(16);
        i_req = 4'b0;
        tick();
      end
    end
    wait_evt(2, 200, "wait_idle_b");

    // Skip of idle requesters, then both bad lengths.
    i_req = 4'b1001;
    exp_gnt.push_back(3);
    tick();
    chk("skip_gnt", 64'(o_gnt), 64'h8);
    exp_cmp.push_back(16 | 3);
    pulse_done(3, 0);
    chk("len0_no_start", 64'(o_tx_start), 64'd0);
    chk("len0_gap", 64'({o_busy, o_gnt}), 64'h10);
    i_req = 4'b0001;
    exp_gnt.push_back(0);
    exp_cmp.push_back(16);
    wait_evt(0, 200, "wait_gnt_c");
    pulse_done(0, 1025);
    chk("len1025_no_start", 64'(o_tx_start), 64'd0);
    chk("len1025_err", 64'(o_err), 64'h1);
    i_req = 4'b0;
    wait_evt(2, 200, "wait_idle_c");

    // Write timeout on requester 2, then done on the final cycle for requester 3.
    i_req = 4'b1100;
    exp_gnt.push_back(2);
    tick();
    chk("tmo_gnt2", 64'(o_gnt), 64'h4);
    gnt_c = cyc;
    exp_cmp.push_back(16 | 2);
    wait_evt(1, 5000, "wait_tmo");
    chk("tmo_cycles", 64'(cyc - gnt_c), 64'd4096);
    chk("tmo_gnt_low", 64'(o_gnt), 64'd0);
    err_c = cyc;
    i_req = 4'b1000;
    exp_gnt.push_back(3);
    wait_evt(0, 200, "wait_gnt_d");
    chk("next_after_gap", 64'(cyc - err_c), 64'd65);
    repeat (4095) tick();
    exp_len.push_back(5);
    exp_cmp.push_back(3);
    pulse_done(3, 5);
    chk("done_at_tmo_wins", 64'(o_tx_start), 64'd1);
    wait_evt(1, 1000, "wait_sent3");
    i_req = 4'b0;
    wait_evt(2, 200, "wait_idle_d");

    // Move the pointer off zero, then reset during SEND.
    i_req = 4'b0010;
    exp_gnt.push_back(1);
    exp_cmp.push_back(16 | 1);
    wait_evt(0, 200, "wait_gnt_e1");
    pulse_done(1, 0);
    i_req = 4'b0;
    wait_evt(2, 200, "wait_idle_e1");
    i_req = 4'b0100;
    exp_gnt.push_back(2);
    wait_evt(0, 200, "wait_gnt_e2");
    exp_len.push_back(2);
    pulse_done(2, 2);
    repeat (10) tick();
    chk("in_send", 64'(o_busy), 64'd1);
    glb_rst = 1'b0;
    #1;
    chk("reset_mid_send", all_outs(), 64'd0);
    i_req = 4'b0;
    tick();
    tick();
    glb_rst = 1'b1;
    i_req = 4'b0101;
    exp_gnt.push_back(0);
    tick();
    chk("post_reset_gnt0", 64'(o_gnt), 64'h1);
    exp_cmp.push_back(16);
    i_req = 4'b0;
    wait_evt(2, 200, "wait_idle_e2");
    tick();

    chk("scoreboard_drained", 64'(exp_gnt.size() + exp_len.size() + exp_cmp.size() + exp_wr.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
